// File: rtl/fifo_buffer_param.sv
// -----------------------------------------------------------------------------
// fifo_buffer_param
// Single-clock synchronous FIFO with storage, pointers and status in one block.
// - Any depth from 2 to 1024. Pointers wrap by an explicit compare against
//   DEPTH-1, so depths that are not a power of 2 work.
// - Registered read port with one clock of latency. rd_valid marks each new
//   word on rd_data.
// - Occupancy count, plus full/empty/almost flags decoded from the count.
// - A write and a read can both be accepted in the same cycle, even when the
//   FIFO is full.
// Optional feature: define FIFO_ERR_STICKY_EN to enable the sticky
// overflow/underflow flags. Without it both flags are tied low and err_clr
// is ignored. The ports exist in both builds.
// -----------------------------------------------------------------------------
module fifo_buffer_param #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 12,
    parameter  int AF_LEVEL   = DEPTH - 2,
    parameter  int AE_LEVEL   = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    // Constants sized to the pointer and count widths, so every compare and
    // increment below is width-exact.
    localparam logic [AW-1:0] LAST_PTR  = (AW)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE   = (AW)'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   AF_CNT    = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0]   AE_CNT    = (AW + 1)'(AE_LEVEL);

    // Storage. It is not reset: a word is only read after it has been written.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Stage p0: pointer and occupancy state.
    logic [AW-1:0] wptr_p0;
    logic [AW-1:0] rptr_p0;
    logic [AW:0]   cnt_p0;

    // Stage p1: registered read word and its valid.
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;

    // Handshake decisions. Both are taken from the state before the edge.
    logic wr_acc;
    logic rd_acc;

    // Advance a pointer. It wraps at DEPTH-1 rather than at 2^AW.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    // Next occupancy. Accepting both a write and a read leaves it unchanged.
    function automatic logic [AW:0] cnt_next(input logic [AW:0] c,
                                             input logic       w,
                                             input logic       r);
        logic [AW:0] n;
        n = c;
        if (w && !r) begin
            n = c + CNT_ONE;
        end else if (r && !w) begin
            n = c - CNT_ONE;
        end
        return n;
    endfunction

    // Status flags decode straight from the registered count. Each flag
    // depends on the count register alone.
    assign empty        = (cnt_p0 == '0);
    assign full         = (cnt_p0 == DEPTH_CNT);
    assign almost_empty = (cnt_p0 <= AE_CNT);
    assign almost_full  = (cnt_p0 >= AF_CNT);
    assign count        = cnt_p0;

    // A read is taken whenever data is present. When the FIFO is full, a write
    // is taken only if a read frees a slot on the same edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Write port. When full with both accepted, wptr equals rptr, and the
    // read below still samples the old word before this edge updates the slot.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_p0] <= wr_data;
        end
    end

    // Pointer and count state. Reset empties the FIFO at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_p0 <= '0;
            rptr_p0 <= '0;
            cnt_p0  <= '0;
        end else begin
            if (wr_acc) begin
                wptr_p0 <= ptr_next(wptr_p0);
            end
            if (rd_acc) begin
                rptr_p0 <= ptr_next(rptr_p0);
            end
            cnt_p0 <= cnt_next(cnt_p0, wr_acc, rd_acc);
        end
    end

    // Stage p1: registered read data. rd_data holds its value when no read
    // is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                rd_data_p1 <= mem[rptr_p0];
            end
        end
    end

    assign rd_data  = rd_data_p1;
    assign rd_valid = vld_p1;

`ifdef FIFO_ERR_STICKY_EN
    logic ovf_q;
    logic unf_q;

    // Sticky error flags. If a clear and a new error arrive in the same
    // cycle, the clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                ovf_q <= 1'b1;
            end
            if (rd_en && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    // Error tracking is compiled out. err_clr has no effect in this build.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

`ifndef SYNTHESIS
    // Simulation-only checks: occupancy stays in range and full/empty are
    // never asserted together.
    a_cnt_bound : assert property (@(posedge clk) disable iff (!reset)
                                   cnt_p0 <= DEPTH_CNT);
    a_flag_excl : assert property (@(posedge clk) disable iff (!reset)
                                   !(empty && full));
`endif

endmodule
